multi_digit_display: RTL and testbench

Parametrised multi-digit 7-segment driver for the MAX10 board HEX displays.
- Captures a binary value on a load strobe.
- Hex mode: splits the value into nibbles. Decimal mode: converts to BCD with a sequential double-dabble (shift-add-3).
- Encodes every digit to active-low segments, with optional leading-zero blanking and overflow indication.
- Sits between datapath/counter logic and the board HEX pins; supersedes the single-nibble combinational decoder.

---
 rtl/multi_digit_display.sv | 208 ++++++++++++++++++++
 tb/tb_multi_digit_display.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_display.sv
// multi_digit_display
//   Multi-digit 7-segment driver for the MAX10 HEX displays. A binary value is
//   captured on a load strobe and shown either as hexadecimal nibbles or, in
//   decimal mode, as BCD produced by a sequential double-dabble. Each digit is
//   encoded to active-low segments. Leading-zero blanking and overflow
//   (all-dash) indication are optional. All outputs are registered.
//
// Ports
//   clk       system clock
//   reset     synchronous active-high reset
//   value     binary value, sampled with load
//   load      start strobe, accepted only while idle
//   mode      0 = hexadecimal, 1 = decimal (sampled with load)
//   blank_lz  1 = blank leading zero digits (sampled with load)
//   busy      high from accepted load until done
//   done      one-cycle pulse, coincident with the first cycle of new segments
//   overflow  value not representable in NUM_DIGITS digits; held until next update
//   segments  active-low segments, digit i = segments[7i+6:7i], bit0=a .. bit6=g
module multi_digit_display #(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_WIDTH = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   value,
   input  logic                    load,
   input  logic                    mode,
   input  logic                    blank_lz,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] segments
);

   localparam int BW = 4 * NUM_DIGITS;
   // One bit wider than both the input and the digit field, so the truncated
   // upper part of a hex value is always a legal (possibly all-zero) slice.
   localparam int XW = ((DATA_WIDTH > BW) ? DATA_WIDTH : BW) + 1;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   bin_q, bin_d;
   logic                    mode_q;
   logic                    blz_q;
   logic [BW-1:0]           bcd_q, bcd_d;
   logic [BW-1:0]           bcd_adj;
   logic                    sticky_q, sticky_d;
   logic [CW-1:0]           cnt_q;
   logic                    phase_q;
   logic [7*NUM_DIGITS-1:0] seg_stage_q, seg_stage_d;
   logic                    ovf_stage_q, ovf_stage_d;
   logic [7*NUM_DIGITS-1:0] seg_q;
   logic                    ovf_q;
   logic                    busy_q;
   logic                    done_q;

   logic [XW-1:0]           ext;
   logic                    hex_ovf;
   logic [BW-1:0]           nib;
   logic                    seen_nz;
   logic [3:0]              dig;

   function automatic logic [6:0] enc7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin}
   // left. A bit leaving the top digit means value >= 10^NUM_DIGITS; it is
   // kept sticky, and the lower digits still resolve correctly.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_d    = {bcd_adj[BW-2:0], bin_q[DATA_WIDTH-1]};
      sticky_d = sticky_q | bcd_adj[BW-1];
      bin_d    = bin_q << 1;
   end

   // Digit selection, overflow, leading-zero blanking and segment encoding.
   always_comb begin
      ext         = XW'(bin_q);
      hex_ovf     = |ext[XW-1:BW];
      nib         = mode_q ? bcd_q : ext[BW-1:0];
      ovf_stage_d = mode_q ? sticky_q : hex_ovf;
      seen_nz     = 1'b0;
      dig         = '0;
      seg_stage_d = '1;
      // Walk from the most significant digit down so "seen_nz" tells whether
      // any higher-or-equal digit is nonzero.
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         dig = nib[4*(NUM_DIGITS-1-k) +: 4];
         if (dig != 4'd0) begin
            seen_nz = 1'b1;
         end
         if (ovf_stage_d) begin
            seg_stage_d[7*(NUM_DIGITS-1-k) +: 7] = SEG_DASH;
         end else if (!blz_q || seen_nz || (k == NUM_DIGITS - 1)) begin
            seg_stage_d[7*(NUM_DIGITS-1-k) +: 7] = enc7(dig);
         end else begin
            seg_stage_d[7*(NUM_DIGITS-1-k) +: 7] = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         mode_q      <= 1'b0;
         blz_q       <= 1'b0;
         bcd_q       <= '0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
         phase_q     <= 1'b0;
         seg_stage_q <= '1;
         ovf_stage_q <= 1'b0;
         seg_q       <= '1;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  bin_q    <= value;
                  mode_q   <= mode;
                  blz_q    <= blank_lz;
                  bcd_q    <= '0;
                  sticky_q <= 1'b0;
                  phase_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (mode) begin
                     cnt_q   <= CW'(DATA_WIDTH);
                     state_q <= SHIFT;
                  end else begin
                     state_q <= UPDATE;
                  end
               end
            end
            SHIFT: begin
               bcd_q    <= bcd_d;
               sticky_q <= sticky_d;
               bin_q    <= bin_d;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               // Two phases: encode into a staging register, then commit to
               // the outputs together with done. Keeps the encoder off the
               // output path and gives the 2 / DATA_WIDTH+2 latency.
               if (!phase_q) begin
                  seg_stage_q <= seg_stage_d;
                  ovf_stage_q <= ovf_stage_d;
                  phase_q     <= 1'b1;
               end else begin
                  seg_q   <= seg_stage_q;
                  ovf_q   <= ovf_stage_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  phase_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign segments = seg_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// tb_multi_digit_display
//   Scoreboard bench for multi_digit_display (NUM_DIGITS=6, DATA_WIDTH=20).
//   Stimulus pushes the expected display computed arithmetically from the
//   value; a monitor pops and compares on every done pulse.
module tb_multi_digit_display;

   localparam int ND = 6;
   localparam int DW = 20;

   typedef struct packed {
      logic [7*ND-1:0] segs;
      logic            ovf;
      int              acc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [DW-1:0]     value = '0;
   logic              load = 1'b0;
   logic              mode = 1'b0;
   logic              blank_lz = 1'b0;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [7*ND-1:0]   segments;

   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   exp_t              sb[$];
   logic [7*ND-1:0]   shown_exp = '1;
   logic [6:0]        enc_tab [16];

   multi_digit_display #(.NUM_DIGITS(ND), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .value    (value),
      .load     (load),
      .mode     (mode),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .segments (segments)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input longint v, input bit m, input bit b, input int acc);
      exp_t   e;
      longint base;
      longint p;
      longint lim;
      base = m ? 64'd10 : 64'd16;
      lim  = 1;
      for (int i = 0; i < ND; i++) lim = lim * base;
      e.ovf = (v >= lim);
      e.acc = acc;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         if (e.ovf)
            e.segs[7*i +: 7] = 7'h3F;
         else if (b && i > 0 && (v / p) == 0)
            e.segs[7*i +: 7] = 7'h7F;
         else
            e.segs[7*i +: 7] = enc_tab[int'((v / p) % base)];
         p = p * base;
      end
      return e;
   endfunction

   // Caller must be at a falling edge; load is sampled at the next rising edge.
   task automatic do_load(input longint v, input bit m, input bit b, input bit expect_it);
      value    = v[DW-1:0];
      mode     = m;
      blank_lz = b;
      load     = 1'b1;
      if (expect_it) sb.push_back(model(v, m, b, cyc + 1));
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         chk("hold_while_busy", longint'(segments), longint'(shown_exp));
         @(negedge clk);
      end
      if (busy) chk("busy_timeout", 1, 0);
   endtask

   task automatic txn(input longint v, input bit m, input bit b);
      int n;
      do_load(v, m, b, 1'b1);
      wait_idle(n);
      chk("busy_cycles", n, m ? DW + 2 : 2);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("segments", longint'(segments), longint'(e.segs));
            chk("overflow", longint'(overflow), longint'(e.ovf));
            chk("latency", cyc - e.acc, (e.segs == e.segs && dut_mode_dec(e)) ? DW + 2 : 2);
            chk("busy_at_done", longint'(busy), 0);
            shown_exp = e.segs;
         end
      end
   end

   // Latency depends on the mode of the transaction; remembered per entry.
   bit mode_hist[$];
   function automatic bit dut_mode_dec(input exp_t e);
      bit m;
      m = (mode_hist.size() != 0) ? mode_hist.pop_front() : 1'b0;
      return m;
   endfunction

   always @(posedge clk) begin
      if (!reset && load && !busy) mode_hist.push_back(mode);
      if (reset) mode_hist.delete();
   end

   initial begin
      int n;
      int r;
      longint v;
      enc_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      // Reset state
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_segments", longint'(segments), longint'({7*ND{1'b1}}));
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_overflow", longint'(overflow), 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases
      txn(64'h0ABCD, 1'b0, 1'b0);
      txn(123456, 1'b1, 1'b0);
      txn(42, 1'b1, 1'b1);
      txn(0, 1'b1, 1'b1);
      txn(1000000, 1'b1, 1'b0);
      chk("overflow_held", longint'(overflow), 1);
      @(negedge clk);
      chk("overflow_held_idle", longint'(overflow), 1);
      txn(7, 1'b1, 1'b0);
      txn(999999, 1'b1, 1'b1);
      txn(64'hFFFFF, 1'b0, 1'b1);
      txn(0, 1'b0, 1'b1);

      // Load while busy is ignored; a load right after done is accepted
      @(negedge clk);
      do_load(5, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      value = 20'd9;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      wait_idle(n);
      chk("busy_cycles_after_ignored", n, DW);
      txn(9, 1'b1, 1'b0);

      // Reset during SHIFT: outputs cleared, no done afterwards
      @(negedge clk);
      do_load(654321, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_segments", longint'(segments), longint'({7*ND{1'b1}}));
      chk("midreset_busy", longint'(busy), 0);
      chk("midreset_done", longint'(done), 0);
      chk("midreset_overflow", longint'(overflow), 0);
      shown_exp = '1;
      repeat (30) @(negedge clk);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      v = $urandom_range(0, 99);
         else if (r == 1) v = $urandom_range(999990, (1 << DW) - 1);
         else             v = $urandom_range(0, (1 << DW) - 1);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         txn(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
